// File: rtl/vc_flit_buffer_pkg.sv
// Shared width helpers for the virtual-channel flit buffer and its per-VC queues.
package vc_flit_buffer_pkg;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned vc_width(input int unsigned vcs);
    return (vcs > 1) ? $clog2(vcs) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vc_queue.sv
// One compacting flit queue: in-order append, indexed extraction with shift-down, per-entry mark bit.
module vc_queue
  import vc_flit_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = idx_width(DEPTH),
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_data,
  input  logic             rem_en,
  input  logic [IDX_W-1:0] rem_idx,
  input  logic             mark_en,
  input  logic             mark_val,
  input  logic [IDX_W-1:0] mark_idx,
  output logic             rem_ok,
  output logic             mark_ok,
  output logic [WIDTH-1:0] rem_data,
  output logic             rem_marked,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             marked;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic               add_hit, rem_hit, mark_hit;
  logic [CNT_W-1:0]   add_pos;

  assign rem_ok     = CNT_W'(rem_idx) < count_q;
  assign mark_ok    = CNT_W'(mark_idx) < count_q;
  assign rem_data   = mem_q[rem_idx].data;
  assign rem_marked = mem_q[rem_idx].marked;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

  // Order matters: mark on the pre-shift index, then compact, then append,
  // so a marked entry travels with its data and a new flit lands after the shift.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    add_hit  = add_en & ~full_q;
    rem_hit  = rem_en & rem_ok;
    mark_hit = mark_en & mark_ok;
    add_pos  = rem_hit ? (count_q - CNT_W'(1)) : count_q;

    if (mark_hit && !(rem_hit && (mark_idx == rem_idx))) begin
      mem_d[mark_idx].marked = mark_val;
    end

    if (rem_hit) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (i >= 32'(rem_idx)) begin
          mem_d[i] = mem_d[i+1];
        end
      end
    end

    if (add_hit) begin
      mem_d[IDX_W'(add_pos)].data   = add_data;
      mem_d[IDX_W'(add_pos)].marked = 1'b0;
    end

    unique case ({add_hit, rem_hit})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i].marked <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/vc_flit_buffer.sv
// Router input-port flit buffer: VCS independent compacting queues with indexed removal and mark bits.
module vc_flit_buffer
  import vc_flit_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned VCS   = 4,
  parameter int unsigned IDX_W = idx_width(DEPTH),
  parameter int unsigned VC_W  = vc_width(VCS),
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 add_valid,
  input  logic [VC_W-1:0]      add_vc,
  input  logic [WIDTH-1:0]     add_data,
  output logic                 add_ready,
  input  logic                 rem_valid,
  input  logic [VC_W-1:0]      rem_vc,
  input  logic [IDX_W-1:0]     rem_idx,
  output logic                 rem_done,
  output logic                 rem_err,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_marked,
  input  logic                 mark_en,
  input  logic                 mark_val,
  input  logic [VC_W-1:0]      mark_vc,
  input  logic [IDX_W-1:0]     mark_idx,
  output logic                 mark_done,
  output logic                 mark_err,
  output logic [VCS-1:0]       full,
  output logic [VCS-1:0]       empty,
  output logic [VCS*CNT_W-1:0] count
);

  logic [VCS-1:0]   q_add_en, q_rem_en, q_mark_en;
  logic [VCS-1:0]   q_rem_ok, q_mark_ok, q_rem_marked;
  logic [VCS-1:0]   q_full, q_empty;
  logic [WIDTH-1:0] q_rem_data [VCS];
  logic [CNT_W-1:0] q_count [VCS];

  logic             sel_rem_ok, sel_mark_ok, sel_marked;
  logic [WIDTH-1:0] sel_data;

  logic             rem_done_q, rem_done_d;
  logic             rem_err_q, rem_err_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_marked_q, out_marked_d;
  logic             mark_done_q, mark_done_d;
  logic             mark_err_q, mark_err_d;

  for (genvar v = 0; v < VCS; v++) begin : g_vc
    vc_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
    ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .add_en     (q_add_en[v]),
      .add_data   (add_data),
      .rem_en     (q_rem_en[v]),
      .rem_idx    (rem_idx),
      .mark_en    (q_mark_en[v]),
      .mark_val   (mark_val),
      .mark_idx   (mark_idx),
      .rem_ok     (q_rem_ok[v]),
      .mark_ok    (q_mark_ok[v]),
      .rem_data   (q_rem_data[v]),
      .rem_marked (q_rem_marked[v]),
      .count      (q_count[v]),
      .full       (q_full[v]),
      .empty      (q_empty[v])
    );
    assign count[v*CNT_W +: CNT_W] = q_count[v];
  end

  assign full  = q_full;
  assign empty = q_empty;

  // An out-of-range VC select matches no queue, so it reports not-ready / error.
  always_comb begin
    q_add_en    = '0;
    q_rem_en    = '0;
    q_mark_en   = '0;
    add_ready   = 1'b0;
    sel_rem_ok  = 1'b0;
    sel_mark_ok = 1'b0;
    sel_data    = '0;
    sel_marked  = 1'b0;
    for (int unsigned v = 0; v < VCS; v++) begin
      if (add_vc == VC_W'(v)) begin
        add_ready   = ~q_full[v];
        q_add_en[v] = add_valid & ~q_full[v];
      end
      if (rem_vc == VC_W'(v)) begin
        q_rem_en[v] = rem_valid;
        sel_rem_ok  = q_rem_ok[v];
        sel_data    = q_rem_data[v];
        sel_marked  = q_rem_marked[v];
      end
      if (mark_vc == VC_W'(v)) begin
        q_mark_en[v] = mark_en;
        sel_mark_ok  = q_mark_ok[v];
      end
    end

    rem_done_d   = rem_valid & sel_rem_ok;
    rem_err_d    = rem_valid & ~sel_rem_ok;
    mark_done_d  = mark_en & sel_mark_ok;
    mark_err_d   = mark_en & ~sel_mark_ok;
    out_data_d   = rem_done_d ? sel_data : out_data_q;
    out_marked_d = rem_done_d ? sel_marked : out_marked_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_done_q   <= 1'b0;
      rem_err_q    <= 1'b0;
      out_data_q   <= '0;
      out_marked_q <= 1'b0;
      mark_done_q  <= 1'b0;
      mark_err_q   <= 1'b0;
    end else begin
      rem_done_q   <= rem_done_d;
      rem_err_q    <= rem_err_d;
      out_data_q   <= out_data_d;
      out_marked_q <= out_marked_d;
      mark_done_q  <= mark_done_d;
      mark_err_q   <= mark_err_d;
    end
  end

  assign rem_done   = rem_done_q;
  assign rem_err    = rem_err_q;
  assign out_data   = out_data_q;
  assign out_marked = out_marked_q;
  assign mark_done  = mark_done_q;
  assign mark_err   = mark_err_q;

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Directed self-checking bench for vc_flit_buffer with default parameters (WIDTH 30, DEPTH 8, VCS 4).
module tb_vc_flit_buffer;

  logic        clk;
  logic        rst;
  logic        add_valid;
  logic [1:0]  add_vc;
  logic [29:0] add_data;
  logic        add_ready;
  logic        rem_valid;
  logic [1:0]  rem_vc;
  logic [2:0]  rem_idx;
  logic        rem_done;
  logic        rem_err;
  logic [29:0] out_data;
  logic        out_marked;
  logic        mark_en;
  logic        mark_val;
  logic [1:0]  mark_vc;
  logic [2:0]  mark_idx;
  logic        mark_done;
  logic        mark_err;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [15:0] count;

  int checks   = 0;
  int failures = 0;

  vc_flit_buffer #(
    .WIDTH (30),
    .DEPTH (8),
    .VCS   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .add_valid  (add_valid),
    .add_vc     (add_vc),
    .add_data   (add_data),
    .add_ready  (add_ready),
    .rem_valid  (rem_valid),
    .rem_vc     (rem_vc),
    .rem_idx    (rem_idx),
    .rem_done   (rem_done),
    .rem_err    (rem_err),
    .out_data   (out_data),
    .out_marked (out_marked),
    .mark_en    (mark_en),
    .mark_val   (mark_val),
    .mark_vc    (mark_vc),
    .mark_idx   (mark_idx),
    .mark_done  (mark_done),
    .mark_err   (mark_err),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt(input int v);
    return count[v*4 +: 4];
  endfunction

  task automatic idle();
    add_valid = 1'b0;
    rem_valid = 1'b0;
    mark_en   = 1'b0;
    mark_val  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add1(input int vc, input logic [29:0] d);
    add_valid = 1'b1;
    add_vc    = 2'(vc);
    add_data  = d;
    tick();
    idle();
  endtask

  task automatic rem1(input int vc, input int idx);
    rem_valid = 1'b1;
    rem_vc    = 2'(vc);
    rem_idx   = 3'(idx);
    tick();
    idle();
  endtask

  task automatic mark1(input int vc, input int idx, input logic val);
    mark_en  = 1'b1;
    mark_vc  = 2'(vc);
    mark_idx = 3'(idx);
    mark_val = val;
    tick();
    idle();
  endtask

  logic [29:0] drain_exp [7];

  initial begin
    rst      = 1'b1;
    add_vc   = '0;
    add_data = '0;
    rem_vc   = '0;
    rem_idx  = '0;
    mark_vc  = '0;
    mark_idx = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_rem_done", 32'(rem_done), 32'h0);

    // Basic add / remove on VC0
    add1(0, 30'h1);
    add1(0, 30'h2);
    add1(0, 30'h3);
    chk("vc0_count3", 32'(cnt(0)), 32'd3);
    chk("vc0_empty", 32'(empty), 32'hE);
    rem1(0, 0);
    chk("rem0_data", 32'(out_data), 32'h1);
    chk("rem0_done", 32'(rem_done), 32'h1);
    chk("rem0_count", 32'(cnt(0)), 32'd2);
    tick();
    chk("rem_done_pulse", 32'(rem_done), 32'h0);

    // Fill VC2, full behaviour, remove from the middle
    for (int i = 0; i < 8; i++) add1(2, 30'(32'h20 + i));
    chk("vc2_full", 32'(full), 32'h4);
    chk("vc2_count8", 32'(cnt(2)), 32'd8);
    add_vc = 2'd2;
    #1;
    chk("vc2_add_ready", 32'(add_ready), 32'h0);
    add_vc = 2'd1;
    #1;
    chk("vc1_add_ready", 32'(add_ready), 32'h1);
    add1(1, 30'h10);
    chk("vc1_count1", 32'(cnt(1)), 32'd1);
    add1(2, 30'h3F);
    chk("vc2_add_when_full", 32'(cnt(2)), 32'd8);
    rem1(2, 3);
    chk("vc2_rem3_data", 32'(out_data), 32'h23);
    chk("vc2_rem3_count", 32'(cnt(2)), 32'd7);
    chk("vc2_not_full", 32'(full), 32'h0);
    drain_exp = '{30'h20, 30'h21, 30'h22, 30'h24, 30'h25, 30'h26, 30'h27};
    for (int i = 0; i < 7; i++) begin
      rem1(2, 0);
      chk($sformatf("vc2_drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
    end
    chk("vc2_empty", 32'(empty), 32'hC);
    rem1(2, 0);
    chk("vc2_rem_empty_err", 32'(rem_err), 32'h1);
    chk("vc2_rem_empty_hold", 32'(out_data), 32'h27);

    // Mark moves with its entry across a shift
    rem1(0, 0);
    rem1(0, 0);
    chk("vc0_clear_last", 32'(out_data), 32'h3);
    add1(0, 30'hA);
    add1(0, 30'hB);
    add1(0, 30'hC);
    add1(0, 30'hD);
    mark1(0, 2, 1'b1);
    chk("mark_c_done", 32'(mark_done), 32'h1);
    rem1(0, 1);
    chk("rem_b_data", 32'(out_data), 32'hB);
    chk("rem_b_marked", 32'(out_marked), 32'h0);
    rem1(0, 1);
    chk("rem_c_data", 32'(out_data), 32'hC);
    chk("rem_c_marked", 32'(out_marked), 32'h1);

    // Range errors on VC3
    add1(3, 30'h30);
    add1(3, 30'h31);
    rem1(3, 5);
    chk("vc3_rem5_err", 32'(rem_err), 32'h1);
    chk("vc3_rem5_nodone", 32'(rem_done), 32'h0);
    chk("vc3_rem5_count", 32'(cnt(3)), 32'd2);
    chk("vc3_rem5_hold", 32'(out_data), 32'hC);
    chk("vc3_rem5_hold_mk", 32'(out_marked), 32'h1);
    rem1(3, 2);
    chk("vc3_rem_eq_count_err", 32'(rem_err), 32'h1);
    mark1(3, 2, 1'b1);
    chk("vc3_mark2_err", 32'(mark_err), 32'h1);
    chk("vc3_mark2_nodone", 32'(mark_done), 32'h0);
    mark1(3, 1, 1'b1);
    chk("vc3_mark1_done", 32'(mark_done), 32'h1);

    // Concurrent remove+add on VC0 with mark on VC1
    add1(0, 30'hE);
    add1(0, 30'hF);
    rem_valid = 1'b1; rem_vc = 2'd0; rem_idx = 3'd0;
    add_valid = 1'b1; add_vc = 2'd0; add_data = 30'h55;
    mark_en = 1'b1; mark_vc = 2'd1; mark_idx = 3'd0; mark_val = 1'b1;
    #1;
    chk("conc_add_ready", 32'(add_ready), 32'h1);
    tick();
    idle();
    chk("conc_out_data", 32'(out_data), 32'hA);
    chk("conc_rem_done", 32'(rem_done), 32'h1);
    chk("conc_count", 32'(cnt(0)), 32'd4);
    chk("conc_mark_done", 32'(mark_done), 32'h1);
    rem1(0, 3);
    chk("conc_new_tail", 32'(out_data), 32'h55);
    rem1(1, 0);
    chk("vc1_marked_data", 32'(out_data), 32'h10);
    chk("vc1_marked_bit", 32'(out_marked), 32'h1);

    // Mark and remove on the same index: old bit reported, write dropped
    rem_valid = 1'b1; rem_vc = 2'd0; rem_idx = 3'd0;
    mark_en = 1'b1; mark_vc = 2'd0; mark_idx = 3'd0; mark_val = 1'b1;
    tick();
    idle();
    chk("same_idx_data", 32'(out_data), 32'hD);
    chk("same_idx_marked", 32'(out_marked), 32'h0);
    chk("same_idx_mark_done", 32'(mark_done), 32'h1);
    rem1(0, 0);
    chk("same_idx_next_data", 32'(out_data), 32'hE);
    chk("same_idx_next_mk", 32'(out_marked), 32'h0);

    // Mark aimed at the slot being added is out of range
    add_valid = 1'b1; add_vc = 2'd0; add_data = 30'h66;
    mark_en = 1'b1; mark_vc = 2'd0; mark_idx = 3'd1; mark_val = 1'b1;
    tick();
    idle();
    chk("mark_add_err", 32'(mark_err), 32'h1);
    chk("mark_add_count", 32'(cnt(0)), 32'd2);
    rem1(0, 1);
    chk("mark_add_data", 32'(out_data), 32'h66);
    chk("mark_add_marked", 32'(out_marked), 32'h0);

    // Full VC: add refused even with a same-cycle remove
    for (int i = 0; i < 8; i++) add1(2, 30'(32'h20 + i));
    rem_valid = 1'b1; rem_vc = 2'd2; rem_idx = 3'd0;
    add_valid = 1'b1; add_vc = 2'd2; add_data = 30'h99;
    #1;
    chk("full_rem_add_ready", 32'(add_ready), 32'h0);
    tick();
    idle();
    chk("full_rem_add_data", 32'(out_data), 32'h20);
    chk("full_rem_add_count", 32'(cnt(2)), 32'd7);

    // Reset mid-operation
    add1(1, 30'h11);
    chk("pre_rst_empty", 32'(empty), 32'h0);
    rst = 1'b1;
    rem_valid = 1'b1; rem_vc = 2'd2; rem_idx = 3'd0;
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_count", 32'(count), 32'h0);
    chk("rst2_rem_done", 32'(rem_done), 32'h0);
    chk("rst2_out_data", 32'(out_data), 32'h0);
    chk("rst2_out_marked", 32'(out_marked), 32'h0);
    chk("rst2_empty", 32'(empty), 32'hF);
    chk("rst2_full", 32'(full), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
